// File: rtl/vga_sync_tracker_pkg.sv
// ============================================================================
// Module      : sync_tracker_pkg
// Description : Shared types and default 640x480 geometry for vga_sync_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_tracker_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam int MATCH_W = 4;

  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;

endpackage

`default_nettype wire

// File: rtl/vga_sync_tracker_if.sv
// ============================================================================
// Module      : vga_sync_tracker_if
// Description : Sync inputs and position/lock outputs of vga_sync_tracker.
//               Measurement outputs exist only with SYNC_TRACKER_MEASURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_tracker_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 10
);

  logic             i_HSync;
  logic             i_VSync;
  logic             o_HSync;
  logic             o_VSync;
  logic [COL_W-1:0] o_Col_Count;
  logic [ROW_W-1:0] o_Row_Count;
  logic             o_Active;
  logic             o_Frame_Start;
  logic             o_Locked;
  logic             o_Sync_Error;
`ifdef SYNC_TRACKER_MEASURE_EN
  logic [COL_W-1:0] o_Line_Len;
  logic [ROW_W-1:0] o_Frame_Len;

  modport master (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Locked, o_Sync_Error, o_Line_Len, o_Frame_Len
  );

  modport slave (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Locked, o_Sync_Error, o_Line_Len, o_Frame_Len
  );
`else
  modport master (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Locked, o_Sync_Error
  );

  modport slave (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Locked, o_Sync_Error
  );
`endif

endinterface

`default_nettype wire

// File: rtl/vga_sync_tracker_edge.sv
// ============================================================================
// Module      : sync_edge_detect
// Description : One-cycle sync delay plus asserted-edge detect on the
//               polarity-normalised sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Sync,
  output logic o_Sync,
  output logic o_Edge
);

  logic norm;
  logic hist_q, hist_d;
  logic sync_q, sync_d;

  always_comb begin
    norm   = (SYNC_ACTIVE_HIGH != 0) ? i_Sync : ~i_Sync;
    hist_d = norm;
    sync_d = i_Sync;
    o_Edge = norm & ~hist_q;
  end

  // History resets to asserted so a sync already active at release is not an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hist_q <= 1'b1;
      sync_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      sync_q <= sync_d;
    end
  end

  assign o_Sync = sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_sync_tracker.sv
// ============================================================================
// Module      : vga_sync_tracker
// Description : Delays H/V sync one cycle, derives aligned col/row counters,
//               active flag, frame-start pulse and geometry lock detection.
//               Define SYNC_TRACKER_MEASURE_EN for line/frame length outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_tracker
  import sync_tracker_pkg::*;
#(
  parameter int COL_W            = 10,
  parameter int ROW_W            = 10,
  parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  vga_sync_tracker_if.slave bus
);

  localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST     = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W:0]     ACT_COLS     = (COL_W + 1)'(ACTIVE_COLS);
  localparam logic [ROW_W:0]     ACT_ROWS     = (ROW_W + 1)'(ACTIVE_ROWS);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_FRAMES);

  logic line_edge, frame_edge;
  logic col_end, frame_wrap, consistent, inconsistent;

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               active_q, active_d;
  logic               frame_start_q, frame_start_d;
  logic               locked_q, locked_d;
  logic               sync_error_q, sync_error_d;
  lock_state_e        state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;

  sync_edge_detect #(.SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_hsync_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sync  (bus.i_HSync),
    .o_Sync  (bus.o_HSync),
    .o_Edge  (line_edge)
  );

  sync_edge_detect #(.SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_vsync_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sync  (bus.i_VSync),
    .o_Sync  (bus.o_VSync),
    .o_Edge  (frame_edge)
  );

  always_comb begin
    col_end      = (col_q == COL_LAST);
    frame_wrap   = col_end && (row_q == ROW_LAST);
    consistent   = frame_edge && frame_wrap;
    // A VSync edge off the wrap point, or a wrap with no VSync, both count.
    inconsistent = frame_edge ^ frame_wrap;

    col_d = col_q + 1'b1;
    row_d = row_q;
    if (frame_edge) begin
      col_d = '0;
      row_d = '0;
    end else if (col_end) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    active_d      = ({1'b0, col_d} < ACT_COLS) && ({1'b0, row_d} < ACT_ROWS);
    frame_start_d = frame_edge;

    state_d      = state_q;
    match_d      = match_q;
    sync_error_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (frame_edge) begin
          state_d = ACQUIRE;
          match_d = '0;
        end
      end
      ACQUIRE: begin
        if (consistent) begin
          match_d = match_q + 1'b1;
          if (match_d == MATCH_TARGET) begin
            state_d = LOCKED;
          end
        end else if (inconsistent) begin
          match_d      = '0;
          sync_error_d = 1'b1;
        end
      end
      LOCKED: begin
        if (inconsistent) begin
          state_d      = ACQUIRE;
          match_d      = '0;
          sync_error_d = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        match_d = '0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q         <= '0;
      row_q         <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_error_q  <= 1'b0;
      state_q       <= SEARCH;
      match_q       <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_error_q  <= sync_error_d;
      state_q       <= state_d;
      match_q       <= match_d;
    end
  end

  assign bus.o_Col_Count   = col_q;
  assign bus.o_Row_Count   = row_q;
  assign bus.o_Active      = active_q;
  assign bus.o_Frame_Start = frame_start_q;
  assign bus.o_Locked      = locked_q;
  assign bus.o_Sync_Error  = sync_error_q;

`ifdef SYNC_TRACKER_MEASURE_EN
  logic [COL_W-1:0] line_cnt_q, line_cnt_d, line_len_q, line_len_d;
  logic [ROW_W-1:0] frame_cnt_q, frame_cnt_d, frame_len_q, frame_len_d;

  // Counters start at 1 on their own edge so the loaded value is the period.
  always_comb begin
    line_cnt_d  = line_cnt_q;
    line_len_d  = line_len_q;
    frame_cnt_d = frame_cnt_q;
    frame_len_d = frame_len_q;

    if (line_edge) begin
      line_len_d = line_cnt_q;
      line_cnt_d = COL_W'(1);
    end else if (line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end

    if (frame_edge) begin
      frame_len_d = frame_cnt_q;
      frame_cnt_d = line_edge ? ROW_W'(1) : '0;
    end else if (line_edge && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      line_cnt_q  <= '0;
      line_len_q  <= '0;
      frame_cnt_q <= '0;
      frame_len_q <= '0;
    end else begin
      line_cnt_q  <= line_cnt_d;
      line_len_q  <= line_len_d;
      frame_cnt_q <= frame_cnt_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign bus.o_Line_Len  = line_len_q;
  assign bus.o_Frame_Len = frame_len_q;
`else
  logic unused_line_edge;
  assign unused_line_edge = line_edge;
`endif

endmodule

`default_nettype wire
